// File: rtl/button_debouncer_pkg.sv
// Shared encodings for the button front-end: FSM state codes and the press counter width.
package button_debouncer_pkg;

  localparam logic [1:0] ST_IDLE         = 2'b00;
  localparam logic [1:0] ST_PRESS_WAIT   = 2'b01;
  localparam logic [1:0] ST_PRESSED      = 2'b11;
  localparam logic [1:0] ST_RELEASE_WAIT = 2'b10;

  localparam int PRESS_CNT_W = 8;

  typedef enum logic [1:0] {
    IDLE         = ST_IDLE,
    PRESS_WAIT   = ST_PRESS_WAIT,
    PRESSED      = ST_PRESSED,
    RELEASE_WAIT = ST_RELEASE_WAIT
  } state_t;

  // The encoding puts the debounced level in bit 1 (PRESSED and RELEASE_WAIT).
  function automatic logic is_down(state_t s);
    return s[1];
  endfunction

endpackage

// File: rtl/button_debouncer_if.sv
// Button-side bundle: raw input towards the debouncer, conditioned level/pulses/count back.
interface button_debouncer_if;
  logic                                        btn_in;
  logic                                        btn_state;
  logic                                        press_pulse;
  logic                                        release_pulse;
  logic [button_debouncer_pkg::PRESS_CNT_W-1:0] press_count;

  modport master (
    output btn_in,
    input  btn_state, press_pulse, release_pulse, press_count
  );

  modport slave (
    input  btn_in,
    output btn_state, press_pulse, release_pulse, press_count
  );
endinterface

// File: rtl/button_debouncer_sync_2ff.sv
// 1-bit two-flop synchroniser, async active-high reset to 0; reused for every raw button.
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic i_d,
  output logic o_q
);

  logic [1:0] r_pipe;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_pipe <= '0;
    else     r_pipe <= {r_pipe[0], i_d};
  end

  assign o_q = r_pipe[1];

endmodule

// File: rtl/button_debouncer.sv
// Debounces one raw button: synchronise, qualify over STABLE_CYCLES samples, emit level,
// single-cycle press/release pulses and a wrapping press count.
module button_debouncer
  import button_debouncer_pkg::*;
#(
  parameter int STABLE_CYCLES = 16,
  parameter int CNT_W         = $clog2(STABLE_CYCLES + 1)
) (
  input  logic               clk,
  input  logic               rst,
  button_debouncer_if.slave  bus
);

  logic                   w_s2;
  logic                   w_last;
  state_t                 r_state, w_state_nxt;
  logic [CNT_W-1:0]       r_cnt, w_cnt_nxt;
  logic                   r_btn_state;
  logic                   r_press, w_press_nxt;
  logic                   r_release, w_release_nxt;
  logic [PRESS_CNT_W-1:0] r_count, w_count_nxt;

  sync_2ff u_sync (
    .clk (clk),
    .rst (rst),
    .i_d (bus.btn_in),
    .o_q (w_s2)
  );

  assign w_last = (r_cnt == CNT_W'(STABLE_CYCLES - 1));

  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_press_nxt   = 1'b0;
    w_release_nxt = 1'b0;
    w_count_nxt   = r_count;
    case (r_state)
      IDLE: begin
        if (w_s2) begin
          w_state_nxt = PRESS_WAIT;
          w_cnt_nxt   = '0;
        end
      end
      PRESS_WAIT: begin
        if (!w_s2) begin
          w_state_nxt = IDLE;
        end else if (w_last) begin
          w_state_nxt = PRESSED;
          w_press_nxt = 1'b1;
          w_count_nxt = r_count + PRESS_CNT_W'(1);
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      PRESSED: begin
        if (!w_s2) begin
          w_state_nxt = RELEASE_WAIT;
          w_cnt_nxt   = '0;
        end
      end
      RELEASE_WAIT: begin
        if (w_s2) begin
          w_state_nxt = PRESSED;
        end else if (w_last) begin
          w_state_nxt   = IDLE;
          w_release_nxt = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Level is registered off the next state so it changes on the same edge as the state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_btn_state <= 1'b0;
      r_press     <= 1'b0;
      r_release   <= 1'b0;
      r_count     <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_btn_state <= is_down(w_state_nxt);
      r_press     <= w_press_nxt;
      r_release   <= w_release_nxt;
      r_count     <= w_count_nxt;
    end
  end

  assign bus.btn_state     = r_btn_state;
  assign bus.press_pulse   = r_press;
  assign bus.release_pulse = r_release;
  assign bus.press_count   = r_count;

endmodule
